fifo_read_stream: RTL
=====================

Name: fifo_read_stream

Overview:
- Read-domain stage directly downstream of async_fifo.
- Drives the FIFO read port (p_read_en / p_read_data / p_read_empty) and re-presents the words as a valid/ready stream with full one-word-per-cycle throughput.
- Marks packet boundaries every PKT_LEN words and counts delivered words.
- Runs entirely on the FIFO read clock.

Parameters:
- BITS, 32, width of each data word; must match async_fifo BITS.
- READ_LATENCY, 1, cycles from an accepted p_read_en to valid p_read_data; legal values 0 and 1.
- DEPTH, 2, internal prefetch buffer entries; minimum 2.
- PKT_LEN, 4, words per packet for m_last; 0 disables m_last.
- COUNT_BITS, 32, width of word_count.

Ports:
- clk  in  1  FIFO read clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- drain_en  in  1  permits new FIFO reads when 1.
- p_read_en  out  1  read request to async_fifo.
- p_read_data  in  BITS  read data from async_fifo.
- p_read_empty  in  1  FIFO empty flag.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts the word.
- m_data  out  BITS  output word.
- m_last  out  1  final word of a packet; qualified by m_valid.
- word_count  out  COUNT_BITS  total words accepted downstream.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: p_read_en=0, m_valid=0, m_data=0, m_last=0, word_count=0. Buffer occupancy, in-flight count and beat counter all cleared.
- Reset mid-operation: buffered and in-flight words are discarded, not delivered. Any FIFO word whose read was already accepted is lost; this is intended, because upstream resets the FIFO alongside.
- Read issue (combinational):
  - p_read_en = !rst && drain_en && !p_read_empty && (occ + inflight - pop < DEPTH).
  - pop = m_valid && m_ready in the same cycle.
  - Never assert p_read_en while p_read_empty=1.
- READ_LATENCY=1:
  - A read accepted in cycle N captures p_read_data at the end of cycle N+1.
  - inflight is a 1-bit register.
  - First word reaches m_valid in cycle N+2.
- READ_LATENCY=0:
  - p_read_data is captured at the end of cycle N; inflight is always 0.
  - First word reaches m_valid in cycle N+1.
- Buffer:
  - DEPTH-entry circular buffer; read and write pointers wrap modulo DEPTH.
  - m_data and m_valid come from the head entry.
  - m_valid = (occ != 0).
  - Push and pop in the same cycle leave occ unchanged.
  - Overflow is impossible by the credit rule. A capture with occ==DEPTH is an assertion failure.
- Stream handshake:
  - A word transfers when m_valid && m_ready.
  - While m_valid=1 and m_ready=0, m_data and m_last hold stable.
  - m_valid never drops without a transfer, except on reset.
- Throughput: with m_ready held 1 and the FIFO non-empty, one word per cycle is sustained for both latencies.
- Packet framing:
  - A beat counter counts transfers and wraps 0..PKT_LEN-1.
  - m_last = m_valid && (beat == PKT_LEN-1).
  - The counter advances only on transfer.
  - PKT_LEN=1 gives m_last on every word. PKT_LEN=0 ties m_last to 0.
- word_count: increments by 1 per transfer and wraps modulo 2^COUNT_BITS.
- drain_en=0:
  - No new reads are issued.
  - Buffered and in-flight words are still delivered.
  - Beat and word counts are preserved.
- Simultaneous events: capture, pop and a new read in one cycle are all legal. Ordering is preserved strictly FIFO.

Test Plan:
- Reset: hold rst=1 for 3 clks with FIFO holding 5 words -> p_read_en=0, m_valid=0, word_count=0 throughout; no FIFO word consumed.
- Smoke: write 0x0..0xF into async_fifo, m_ready=1, READ_LATENCY=1 -> m_data emits 0x0..0xF in order, m_last on 0x3, 0x7, 0xB, 0xF, word_count=16; first m_valid 2 clks after p_read_empty falls.
- Back-pressure: 8 words queued, m_ready toggles 1,0,0,1,... -> no drop or duplicate; m_data stable while stalled; p_read_en deasserts once occ+inflight=DEPTH.
- Throughput: 64 words pre-filled, m_ready=1 -> 64 consecutive cycles with m_valid=1, word_count=64.
- drain_en: deassert after 3 words delivered -> at most DEPTH further words delivered, then m_valid=0 with FIFO still non-empty; re-assert -> stream resumes in order, beat phase continues (m_last at 4th overall word).
- Mid-operation reset: pulse rst for 1 clk during a sustained stream -> all outputs 0 the next cycle; restart delivers the next FIFO word with beat restarting at 0 and word_count=0.

Source files
------------

// File: rtl/fifo_read_stream.sv
// fifo_read_stream: drains the async_fifo read port (p_read_*) into a valid/ready stream (m_*) with PKT_LEN framing and a delivered-word count
module fifo_read_stream #(
  parameter int BITS = 32,
  parameter int READ_LATENCY = 1,
  parameter int DEPTH = 2,
  parameter int PKT_LEN = 4,
  parameter int COUNT_BITS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  drain_en,
  output logic                  p_read_en,
  input  logic [BITS-1:0]       p_read_data,
  input  logic                  p_read_empty,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [BITS-1:0]       m_data,
  output logic                  m_last,
  output logic [COUNT_BITS-1:0] word_count
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);
  localparam int BW = PKT_LEN > 1 ? $clog2(PKT_LEN) : 1;
  logic [BITS-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [OW-1:0] occ;
  logic [BW-1:0] beat;
  logic inflight, push, pop;
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    pop = m_valid && m_ready;
    push = READ_LATENCY == 0 ? p_read_en : inflight;
    p_read_en = !rst && drain_en && !p_read_empty && (int'(occ) + int'(inflight) - int'(pop) < DEPTH);
    m_valid = occ != '0;
    m_data = m_valid ? mem[rd_ptr] : '0;
    m_last = PKT_LEN != 0 && m_valid && beat == BW'(PKT_LEN - 1);
  end
  always_ff @(posedge clk)
    inflight <= READ_LATENCY != 0 && p_read_en;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= p_read_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ <= '0;
      beat <= '0;
      word_count <= '0;
    end else begin
      if (push) wr_ptr <= wrap_inc(wr_ptr);
      if (pop) rd_ptr <= wrap_inc(rd_ptr);
      occ <= occ + OW'(push) - OW'(pop);
      if (pop) word_count <= word_count + 1'b1;
      if (pop) beat <= (PKT_LEN == 0 || beat == BW'(PKT_LEN - 1)) ? '0 : beat + 1'b1;
    end
  end
  assert property (@(posedge clk) disable iff (rst) !(push && occ == OW'(DEPTH)));
endmodule
